lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 142 ++++++++++++++
 tb/tb_lsu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit bridging a single-issue core to a local synchronous-read bus.
// One request in flight: IDLE -> ACCESS -> (LWAIT) -> RESP, errors go straight to RESP.
module lsu #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_store,
   input  logic [2:0]         req_funct3,
   input  logic [XLEN-1:0]    req_addr,
   input  logic [XLEN-1:0]    req_wdata,
   output logic               rsp_valid,
   output logic               rsp_err,
   output logic [XLEN-1:0]    rsp_rdata,
   output logic [XLEN-1:0]    bus_addr,
   output logic [XLEN-1:0]    bus_qin,
   output logic [XLEN/8-1:0]  bus_we,
   input  logic [XLEN-1:0]    bus_qout
);

   localparam int NB = XLEN / 8;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LWAIT, S_RESP} state_t;

   state_t            r_state, w_next;
   logic              r_store;
   logic [2:0]        r_funct3;
   logic [1:0]        r_alo;
   logic              r_rsp_valid, r_rsp_err;
   logic [XLEN-1:0]   r_rsp_rdata, r_bus_addr, r_bus_qin;
   logic [NB-1:0]     r_bus_we;

   logic              w_accept, w_illegal;
   logic [NB-1:0]     w_we_mask;
   logic [XLEN-1:0]   w_wdata_rep, w_ldata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;

   assign req_ready = (r_state == S_IDLE) & ~rst;
   assign w_accept  = req_valid & req_ready;

   // Size/alignment legality of the incoming request
   always_comb begin
      w_illegal = 1'b0;
      if (req_store) w_illegal = (req_funct3 > 3'b010);
      else           w_illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      if (req_funct3[1:0] == 2'b01 && req_addr[0])          w_illegal = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) w_illegal = 1'b1;
   end

   always_comb begin
      w_we_mask   = '1;
      w_wdata_rep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_we_mask   = NB'(1) << req_addr[1:0];
            w_wdata_rep = {(XLEN/8){req_wdata[7:0]}};
         end
         2'b01: begin
            w_we_mask   = NB'(3) << req_addr[1:0];
            w_wdata_rep = {(XLEN/16){req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane select and extension of the read word; funct3[2] marks unsigned
   assign w_byte = bus_qout[{r_alo, 3'b000} +: 8];
   assign w_half = bus_qout[{r_alo[1], 4'b0000} +: 16];

   always_comb begin
      w_ldata = bus_qout;
      case (r_funct3[1:0])
         2'b00:   w_ldata = {{(XLEN-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
         2'b01:   w_ldata = {{(XLEN-16){w_half[15] & ~r_funct3[2]}}, w_half};
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = w_illegal ? S_RESP : S_ACCESS;
         S_ACCESS: w_next = r_store ? S_RESP : S_LWAIT;
         S_LWAIT:  w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_store  <= 1'b0;
         r_funct3 <= 3'b000;
         r_alo    <= 2'b00;
      end else if (w_accept) begin
         r_store  <= req_store;
         r_funct3 <= req_funct3;
         r_alo    <= req_addr[1:0];
      end
   end

   // Bus signals are loaded at the accept edge so they appear during ACCESS;
   // enables are a one-cycle pulse, address/data hold until the next legal access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bus_addr  <= '0;
         r_bus_qin   <= '0;
         r_bus_we    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_bus_we <= '0;
         if (w_accept && !w_illegal) begin
            r_bus_addr <= {req_addr[XLEN-1:2], 2'b00};
            if (req_store) begin
               r_bus_we  <= w_we_mask;
               r_bus_qin <= w_wdata_rep;
            end
         end
         r_rsp_valid <= (w_next == S_RESP);
         r_rsp_err   <= w_accept & w_illegal;
         r_rsp_rdata <= (r_state == S_LWAIT) ? w_ldata : '0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign bus_addr  = r_bus_addr;
   assign bus_qin   = r_bus_qin;
   assign bus_we    = r_bus_we;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads with extension, errors, reset abort, back-to-back.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, bus_addr, bus_qin, bus_qout;
   logic [3:0]  bus_we;

   int n_chk = 0;
   int n_err = 0;

   lsu #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .bus_addr(bus_addr), .bus_qin(bus_qin), .bus_we(bus_we), .bus_qout(bus_qout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present a request in cycle T, return in cycle T+1 with req_* scrambled
   task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
      #1;
      chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] xwe,
                           input logic [31:0] xqin, input logic [31:0] xaddr);
      issue(tag, 1'b1, f3, a, d);
      chk({tag, "_addr"}, bus_addr, xaddr);
      chk({tag, "_we"},   {28'd0, bus_we}, {28'd0, xwe});
      chk({tag, "_qin"},  bus_qin, xqin);
      chk({tag, "_v1"},   {31'd0, rsp_valid}, 32'd0);
      tick();
      chk({tag, "_v2"},   {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_err"},  {31'd0, rsp_err}, 32'd0);
      chk({tag, "_rd"},   rsp_rdata, 32'd0);
      chk({tag, "_we2"},  {28'd0, bus_we}, 32'd0);
      tick();
      chk({tag, "_v3"},   {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] q, input logic [31:0] xd);
      bus_qout = ~q;
      issue(tag, 1'b0, f3, a, 32'h0);
      chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
      chk({tag, "_we"},   {28'd0, bus_we}, 32'd0);
      tick();
      bus_qout = q;
      chk({tag, "_v2"},   {31'd0, rsp_valid}, 32'd0);
      tick();
      bus_qout = ~q;
      chk({tag, "_v3"},   {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_err"},  {31'd0, rsp_err}, 32'd0);
      chk({tag, "_rd"},   rsp_rdata, xd);
      tick();
      chk({tag, "_v4"},   {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rdy4"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] xaddr);
      issue(tag, st, f3, a, 32'hCAFE_F00D);
      chk({tag, "_v"},    {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_err"},  {31'd0, rsp_err}, 32'd1);
      chk({tag, "_rd"},   rsp_rdata, 32'd0);
      chk({tag, "_we"},   {28'd0, bus_we}, 32'd0);
      chk({tag, "_addr"}, bus_addr, xaddr);
      tick();
      chk({tag, "_v2"},   {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_err2"}, {31'd0, rsp_err}, 32'd0);
      chk({tag, "_rdy2"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int we_cycles;
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0; bus_qout = 32'h0;
      tick(); tick();
      chk("rst_rdy",  {31'd0, req_ready}, 32'd0);
      chk("rst_v",    {31'd0, rsp_valid}, 32'd0);
      chk("rst_err",  {31'd0, rsp_err}, 32'd0);
      chk("rst_rd",   rsp_rdata, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_qin",  bus_qin, 32'd0);
      chk("rst_we",   {28'd0, bus_we}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_rdy", {31'd0, req_ready}, 32'd1);
      tick();

      do_store("sw", 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1004);
      do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000);
      do_store("sh", 3'b001, 32'h0000_2006, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2004);
      do_store("sb1", 3'b000, 32'h0000_2001, 32'hFFFF_FF3C, 4'b0010, 32'h3C3C_3C3C, 32'h0000_2000);

      do_load("lb",   3'b000, 32'h0000_1002, 32'h1280_3456, 32'hFFFF_FF80);
      do_load("lbu",  3'b100, 32'h0000_1002, 32'h1280_3456, 32'h0000_0080);
      do_load("lhu",  3'b101, 32'h0000_1002, 32'h1280_3456, 32'h0000_1280);
      do_load("lb1",  3'b000, 32'h0000_1001, 32'h1280_3456, 32'h0000_0034);
      do_load("lh0",  3'b001, 32'h0000_1000, 32'h1234_F00D, 32'hFFFF_F00D);
      do_load("lhu0", 3'b101, 32'h0000_1000, 32'h1234_F00D, 32'h0000_F00D);
      do_load("lw",   3'b010, 32'h0000_1000, 32'h8765_4321, 32'h8765_4321);

      do_err("lh_mis",  1'b0, 3'b001, 32'h0000_1001, 32'h0000_1000);
      do_err("sw_mis",  1'b1, 3'b010, 32'h0000_3002, 32'h0000_1000);
      do_err("ld_f011", 1'b0, 3'b011, 32'h0000_3000, 32'h0000_1000);
      do_err("ld_f110", 1'b0, 3'b110, 32'h0000_3000, 32'h0000_1000);
      do_err("st_f100", 1'b1, 3'b100, 32'h0000_3000, 32'h0000_1000);

      // Reset during ACCESS of a load aborts it
      issue("abort", 1'b0, 3'b010, 32'h0000_4000, 32'h0);
      rst = 1'b1;
      tick();
      chk("ab_v",    {31'd0, rsp_valid}, 32'd0);
      chk("ab_err",  {31'd0, rsp_err}, 32'd0);
      chk("ab_rd",   rsp_rdata, 32'd0);
      chk("ab_addr", bus_addr, 32'd0);
      chk("ab_qin",  bus_qin, 32'd0);
      chk("ab_we",   {28'd0, bus_we}, 32'd0);
      chk("ab_rdy0", {31'd0, req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ab_rdy1", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ab_nov", {31'd0, rsp_valid}, 32'd0);
      end

      // req_valid held high: SW then LW back to back
      we_cycles = 0;
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0000_1010; req_wdata = 32'h1122_3344;
      #1;
      chk("bb_rdyT", {31'd0, req_ready}, 32'd1);
      tick();                                    // T+1
      if (bus_we != 4'b0000) we_cycles++;
      chk("bb_we1",  {28'd0, bus_we}, 32'hF);
      chk("bb_rdy1", {31'd0, req_ready}, 32'd0);
      req_store = 1'b0; req_addr = 32'h0000_1010; req_wdata = 32'h0;
      tick();                                    // T+2
      if (bus_we != 4'b0000) we_cycles++;
      chk("bb_v2",   {31'd0, rsp_valid}, 32'd1);
      chk("bb_rdy2", {31'd0, req_ready}, 32'd0);
      tick();                                    // T+3: LW accepted
      if (bus_we != 4'b0000) we_cycles++;
      chk("bb_rdy3", {31'd0, req_ready}, 32'd1);
      chk("bb_v3",   {31'd0, rsp_valid}, 32'd0);
      tick();                                    // T+4
      req_valid = 1'b0;
      if (bus_we != 4'b0000) we_cycles++;
      chk("bb_addr4", bus_addr, 32'h0000_1010);
      tick();                                    // T+5
      if (bus_we != 4'b0000) we_cycles++;
      bus_qout = 32'h1122_3344;
      chk("bb_v5",   {31'd0, rsp_valid}, 32'd0);
      tick();                                    // T+6
      if (bus_we != 4'b0000) we_cycles++;
      chk("bb_v6",   {31'd0, rsp_valid}, 32'd1);
      chk("bb_rd6",  rsp_rdata, 32'h1122_3344);
      chk("bb_wecnt", we_cycles, 32'd1);
      tick();
      chk("bb_v7",   {31'd0, rsp_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
